// File: rtl/vga_fb_pkg.sv
// Shared types and default widths for the VGA framebuffer port arbiter.
package vga_fb_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 8;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_write_t;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// Synchronous write queue for the framebuffer arbiter (module fb_sync_fifo).
// First-word-fall-through head; push when full and pop when empty are ignored.
module fb_sync_fifo
  import vga_fb_pkg::*;
#(
  parameter int W     = $bits(fb_write_t),
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads always win, queued writes fill idle cycles.
// Define FB_ARB_VSYNC_COMMIT_EN to restrict write commits to vertical blanking.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_valid,
  input  logic [ADDR_W-1:0]             disp_addr,
  input  logic                          disp_vblank,
  output logic [DATA_W-1:0]             disp_data,
  output logic                          disp_data_valid,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int WORD_W = ADDR_W + DATA_W;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              commit_ok;
  logic              last_entry;
  logic [WORD_W-1:0] head;
  arb_state_t        state;
  logic              vld_p0;
  logic              vld_p1;

`ifdef FB_ARB_VSYNC_COMMIT_EN
  assign commit_ok = disp_vblank;
`else
  // Any cycle the display leaves the port idle may commit, blanking or not.
  assign commit_ok = !disp_valid || disp_vblank;
`endif

  assign wr_ready   = !full;
  assign push       = wr_valid && wr_ready;
  assign pop        = !disp_valid && commit_ok && !empty && (state != IDLE);
  assign last_entry = (fifo_level == LVL_W'(1));

  fb_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({wr_addr, wr_data}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (push) state <= STALL;
        STALL:   if (pop) state <= (last_entry && !push) ? IDLE : DRAIN;
        DRAIN: begin
          if (!pop)                    state <= STALL;
          else if (last_entry && !push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: registered RAM command; p1: read data returns from RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      mem_en <= disp_valid || pop;
      mem_we <= pop;
      if (disp_valid) begin
        mem_addr <= disp_addr;
      end else if (pop) begin
        mem_addr  <= head[WORD_W-1 -: ADDR_W];
        mem_wdata <= head[DATA_W-1:0];
      end
      vld_p0 <= disp_valid;
      vld_p1 <= vld_p0;
    end
  end

  assign disp_data       = mem_rdata;
  assign disp_data_valid = vld_p1;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a queue/framebuffer-level reference model.
module tb_vga_fb_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
`ifdef FB_ARB_VSYNC_COMMIT_EN
  localparam logic VB_DEF = 1'b1;
`else
  localparam logic VB_DEF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_valid = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_vblank = VB_DEF;
  logic [DW-1:0] disp_data;
  logic          disp_data_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [3:0]    fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_addr(disp_addr), .disp_vblank(disp_vblank),
    .disp_data(disp_data), .disp_data_valid(disp_data_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM: one-cycle synchronous read, write on enable.
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a queue, framebuffer image as an array.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           q[$];
  logic [DW-1:0] fb [2**AW];
  logic          exp_en = 0, exp_we = 0, exp_dvv = 0, dv1 = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0, exp_pix = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      exp_en = 0; exp_we = 0; exp_dvv = 0; dv1 = 0;
      exp_addr = '0; exp_wdata = '0;
    end else begin
      bit  ready, do_pop, commit;
      wr_t w;
      if (exp_en && exp_we)  fb[exp_addr] = exp_wdata;
      if (exp_en && !exp_we) exp_pix = fb[exp_addr];
      exp_dvv = dv1;
      dv1     = disp_valid;
`ifdef FB_ARB_VSYNC_COMMIT_EN
      commit = disp_vblank;
`else
      commit = 1'b1;
`endif
      ready  = q.size() < DEPTH;
      do_pop = !disp_valid && q.size() > 0 && commit;
      exp_en = disp_valid || do_pop;
      exp_we = do_pop;
      if (disp_valid) exp_addr = disp_addr;
      else if (do_pop) begin
        w = q.pop_front();
        exp_addr = w.a;
        exp_wdata = w.d;
      end
      if (wr_valid && ready) begin
        w.a = wr_addr; w.d = wr_data;
        q.push_back(w);
      end
    end
  end

  logic [AW-1:0] seen_wr[$];

  always @(negedge clk) begin
    if (!reset) begin
      check("mem_en", 32'(mem_en), 32'(exp_en));
      check("mem_we", 32'(mem_we), 32'(exp_we));
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      check("fifo_level", 32'(fifo_level), 32'(q.size()));
      check("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
      check("disp_data_valid", 32'(disp_data_valid), 32'(exp_dvv));
      if (exp_dvv) check("disp_data", 32'(disp_data), 32'(exp_pix));
      if (mem_en && mem_we) seen_wr.push_back(mem_addr);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = 8'(i) ^ 8'h5A;
      fb[i]  = 8'(i) ^ 8'h5A;
    end
    ram[17'h10] = 8'hA5;
    fb[17'h10]  = 8'hA5;

    repeat (3) tick();
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_dvv", 32'(disp_data_valid), 0);
    reset = 1'b0;
    tick();
    check("rst_wr_ready", 32'(wr_ready), 1);

    // Single read
    disp_valid = 1; disp_addr = 17'h00010;
    tick();
    disp_valid = 0;
    check("rd_en", 32'(mem_en), 1);
    check("rd_we", 32'(mem_we), 0);
    check("rd_addr", 32'(mem_addr), 32'h10);
    tick();
    check("rd_data", 32'(disp_data), 32'hA5);
    check("rd_dvv", 32'(disp_data_valid), 1);

    // Write while display idle
    wr_valid = 1; wr_addr = 17'h00123; wr_data = 8'h3C;
    tick();
    wr_valid = 0;
    check("wr_level1", 32'(fifo_level), 1);
    tick();
    check("wr_we", 32'(mem_we), 1);
    check("wr_addr", 32'(mem_addr), 32'h123);
    check("wr_wdata", 32'(mem_wdata), 32'h3C);
    check("wr_level0", 32'(fifo_level), 0);

    // Contention: ten display reads, three queued writes
    for (int i = 0; i < 10; i++) begin
      disp_valid = 1; disp_addr = AW'(32'h200 + i);
      wr_valid = (i < 3);
      wr_addr = AW'(32'h300 + i); wr_data = DW'(8'h40 + i);
      tick();
      check("cont_no_we", 32'(mem_we), 0);
    end
    disp_valid = 0; wr_valid = 0;
    check("cont_level", 32'(fifo_level), 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cont_order_we", 32'(mem_we), 1);
      check("cont_order_addr", 32'(mem_addr), 32'h300 + i);
      check("cont_order_data", 32'(mem_wdata), 32'h40 + i);
    end
    tick();

    // Full queue with the display holding the port
    seen_wr.delete();
    disp_valid = 1;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; wr_addr = AW'(32'h400 + i); wr_data = DW'(8'h80 + i);
      tick();
    end
    wr_addr = 17'h00408; wr_data = 8'h88;
    tick();
    check("full_ready", 32'(wr_ready), 0);
    check("full_level", 32'(fifo_level), 8);
    tick();
    check("full_hold", 32'(wr_ready), 0);
    disp_valid = 0;
    begin
      int budget = 20;
      while (!wr_ready && budget > 0) begin
        tick();
        budget--;
      end
      check("full_ready_timeout", 32'(budget > 0), 1);
    end
    tick();
    wr_valid = 0;
    repeat (10) tick();
    check("full_count", 32'(seen_wr.size()), 9);
    for (int k = 0; k < seen_wr.size() && k < 9; k++)
      check("full_order", 32'(seen_wr[k]), 32'h400 + k);

    // Reset in the middle of a drain with a read in flight
    disp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = AW'(32'h500 + i); wr_data = DW'(8'hC0 + i);
      tick();
    end
    wr_valid = 0;
    tick();
    disp_valid = 0;
    tick();
    check("mid_we_before", 32'(mem_we), 1);
    check("mid_dvv_before", 32'(disp_data_valid), 1);
    reset = 1;
    #1;
    check("mid_rst_en", 32'(mem_en), 0);
    check("mid_rst_we", 32'(mem_we), 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    check("mid_rst_wdata", 32'(mem_wdata), 0);
    check("mid_rst_dvv", 32'(disp_data_valid), 0);
    check("mid_rst_level", 32'(fifo_level), 0);
    tick();
    tick();
    reset = 0;
    tick();
    check("mid_rel_ready", 32'(wr_ready), 1);
    check("mid_rel_en", 32'(mem_en), 0);

    // Back-to-back reads: one written pixel, one whose write was lost
    disp_valid = 1; disp_addr = 17'h00123;
    tick();
    disp_addr = 17'h00500;
    tick();
    disp_valid = 0;
    check("bb_pix0", 32'(disp_data), 32'h3C);
    tick();
    check("bb_pix1", 32'(disp_data), 32'h5A);
    check("bb_dvv", 32'(disp_data_valid), 1);

`ifdef FB_ARB_VSYNC_COMMIT_EN
    // Commit gate: writes wait for vertical blanking
    disp_vblank = 0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1; wr_addr = AW'(32'h600 + i); wr_data = DW'(8'hE0 + i);
      tick();
    end
    wr_valid = 0;
    repeat (3) begin
      tick();
      check("gate_no_we", 32'(mem_we), 0);
    end
    check("gate_level", 32'(fifo_level), 2);
    disp_vblank = 1;
    tick();
    check("gate_we0", 32'(mem_we), 1);
    check("gate_addr0", 32'(mem_addr), 32'h600);
    tick();
    check("gate_we1", 32'(mem_we), 1);
    check("gate_addr1", 32'(mem_addr), 32'h601);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
